fp_special_classify: RTL and testbench

//  Parametrised 2-stage front end of the FP adder/subtracter. Classifies operands A and B
//  (zero, subnormal, normal, inf, qNaN, sNaN), resolves every special-case add/sub result
//  as a bypass, and tags normal operands for the main datapath. Adds valid/ready flow

---
 rtl/fp_special_pkg.sv | 21 ++
 rtl/fp_special_classify_if.sv | 34 +++
 rtl/fp_operand_classify.sv | 27 ++
 rtl/fp_special_classify.sv | 159 +++++++++++++++
 tb/tb_fp_special_classify.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_special_pkg.sv
// rtl/fp_special_pkg.sv - operand class encoding and canonical quiet-NaN constant for the FP add/sub front end
package fp_special_pkg;

    typedef enum logic [2:0] {
        FPC_NORM = 3'd0,
        FPC_ZERO = 3'd1,
        FPC_INF  = 3'd2,
        FPC_QNAN = 3'd3,
        FPC_SNAN = 3'd4,
        FPC_SUBN = 3'd5
    } fp_class_t;

    // Canonical qNaN: sign 0, exponent all ones, only the mantissa MSB set.
    function automatic logic [63:0] qnan(input int exp_w, input int mant_w);
        logic [63:0] w;
        w = ((64'd1 << exp_w) - 64'd1) << mant_w;
        w = w | (64'd1 << (mant_w - 1));
        return w;
    endfunction

endpackage

// File: rtl/fp_special_classify_if.sv
// rtl/fp_special_classify_if.sv - operand-in / classified-result-out stream bundle
interface fp_special_classify_if
    import fp_special_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
);
    localparam int FP_W = 1 + EXP_W + MANT_W;

    logic            in_valid;
    logic            in_ready;
    logic [FP_W-1:0] op_a;
    logic [FP_W-1:0] op_b;
    logic            op_sub;

    logic            out_valid;
    logic            out_ready;
    fp_class_t       class_a;
    fp_class_t       class_b;
    logic            bypass;
    logic [FP_W-1:0] result;
    logic            invalid;

    modport master (
        output in_valid, op_a, op_b, op_sub, out_ready,
        input  in_ready, out_valid, class_a, class_b, bypass, result, invalid
    );

    modport slave (
        input  in_valid, op_a, op_b, op_sub, out_ready,
        output in_ready, out_valid, class_a, class_b, bypass, result, invalid
    );

endinterface

// File: rtl/fp_operand_classify.sv
// rtl/fp_operand_classify.sv - combinational IEEE-754 class decode of one operand (sign handled by caller)
module fp_operand_classify
    import fp_special_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic [EXP_W-1:0]  exp_f,
    input  logic [MANT_W-1:0] mant,
    output fp_class_t         cls
);

    always_comb begin
        cls = FPC_NORM;
        if (&exp_f) begin
            if (mant == '0)
                cls = FPC_INF;
            else if (mant[MANT_W-1])
                cls = FPC_QNAN;
            else
                cls = FPC_SNAN;
        end else if (exp_f == '0) begin
            cls = (mant == '0) ? FPC_ZERO : FPC_SUBN;
        end
    end

endmodule

// File: rtl/fp_special_classify.sv
// rtl/fp_special_classify.sv - two-stage special-case resolver in front of the FP adder/subtracter
module fp_special_classify
    import fp_special_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fp_special_classify_if.slave bus,
    input  logic                 clr_flags,
    output logic                 flag_invalid,
    output logic [CNT_W-1:0]     bypass_cnt
);

    localparam int FP_W = 1 + EXP_W + MANT_W;
    localparam logic [FP_W-1:0] QNAN_W = FP_W'(qnan(EXP_W, MANT_W));

    logic [FP_W-1:0] b_eff;
    fp_class_t       in_cls_a;
    fp_class_t       in_cls_b;

    logic            s1_valid;
    fp_class_t       s1_cls_a;
    fp_class_t       s1_cls_b;
    logic [FP_W-1:0] s1_a;
    logic [FP_W-1:0] s1_b;

    logic            s2_valid;
    fp_class_t       s2_cls_a;
    fp_class_t       s2_cls_b;
    logic            s2_bypass;
    logic [FP_W-1:0] s2_result;
    logic            s2_invalid;

    logic            s2_advance;
    logic            out_hs;

    logic            nx_bypass;
    logic [FP_W-1:0] nx_result;
    logic            nx_invalid;

    // Subtraction is folded into B's sign up front so the rules only ever see an add.
    assign b_eff = {bus.op_b[FP_W-1] ^ bus.op_sub, bus.op_b[FP_W-2:0]};

    fp_operand_classify #(.EXP_W(EXP_W), .MANT_W(MANT_W)) u_cls_a (
        .exp_f (bus.op_a[FP_W-2:MANT_W]),
        .mant  (bus.op_a[MANT_W-1:0]),
        .cls   (in_cls_a)
    );

    fp_operand_classify #(.EXP_W(EXP_W), .MANT_W(MANT_W)) u_cls_b (
        .exp_f (b_eff[FP_W-2:MANT_W]),
        .mant  (b_eff[MANT_W-1:0]),
        .cls   (in_cls_b)
    );

    assign s2_advance   = !s2_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || s2_advance;
    assign out_hs       = s2_valid && bus.out_ready;

    always_comb begin
        logic sa, sb;
        logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        sa     = s1_a[FP_W-1];
        sb     = s1_b[FP_W-1];
        nan_a  = (s1_cls_a == FPC_QNAN) || (s1_cls_a == FPC_SNAN);
        nan_b  = (s1_cls_b == FPC_QNAN) || (s1_cls_b == FPC_SNAN);
        inf_a  = (s1_cls_a == FPC_INF);
        inf_b  = (s1_cls_b == FPC_INF);
        zero_a = (s1_cls_a == FPC_ZERO);
        zero_b = (s1_cls_b == FPC_ZERO);

        nx_bypass  = 1'b1;
        nx_result  = '0;
        nx_invalid = 1'b0;
        if (nan_a || nan_b) begin
            nx_result  = QNAN_W;
            nx_invalid = (s1_cls_a == FPC_SNAN) || (s1_cls_b == FPC_SNAN);
        end else if (inf_a && inf_b && (sa != sb)) begin
            nx_result  = QNAN_W;
            nx_invalid = 1'b1;
        end else if (inf_a) begin
            nx_result = s1_a;
        end else if (inf_b) begin
            nx_result = s1_b;
        end else if (zero_a && zero_b) begin
            nx_result[FP_W-1] = sa && sb;
        end else if (zero_a) begin
            nx_result = s1_b;
        end else if (zero_b) begin
            nx_result = s1_a;
        end else begin
            nx_bypass = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_cls_a <= FPC_NORM;
            s1_cls_b <= FPC_NORM;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_cls_a <= in_cls_a;
                s1_cls_b <= in_cls_b;
                s1_a     <= bus.op_a;
                s1_b     <= b_eff;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            s2_cls_a   <= FPC_NORM;
            s2_cls_b   <= FPC_NORM;
            s2_bypass  <= 1'b0;
            s2_result  <= '0;
            s2_invalid <= 1'b0;
        end else if (s2_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_cls_a   <= s1_cls_a;
                s2_cls_b   <= s1_cls_b;
                s2_bypass  <= nx_bypass;
                s2_result  <= nx_result;
                s2_invalid <= nx_invalid;
            end
        end
    end

    // A clear coinciding with a handshake restarts the statistics from that pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_invalid <= 1'b0;
            bypass_cnt   <= '0;
        end else if (clr_flags) begin
            flag_invalid <= out_hs && s2_invalid;
            bypass_cnt   <= (out_hs && s2_bypass) ? CNT_W'(1) : '0;
        end else if (out_hs) begin
            flag_invalid <= flag_invalid | s2_invalid;
            if (s2_bypass && (bypass_cnt != '1))
                bypass_cnt <= bypass_cnt + CNT_W'(1);
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.class_a   = s2_cls_a;
    assign bus.class_b   = s2_cls_b;
    assign bus.bypass    = s2_bypass;
    assign bus.result    = s2_result;
    assign bus.invalid   = s2_invalid;

endmodule

// File: tb/tb_fp_special_classify.sv
// tb/tb_fp_special_classify.sv - self-checking bench for fp_special_classify (binary32, 4-bit counter)
module tb_fp_special_classify;
    import fp_special_pkg::*;

    typedef struct {
        fp_class_t   ca;
        fp_class_t   cb;
        logic        byp;
        logic [31:0] res;
        logic        inv;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        fixed;
        logic        byp;
        logic [31:0] res;
        logic        inv;
    } pair_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr_flags;
    logic       flag_invalid;
    logic [3:0] bypass_cnt;

    fp_special_classify_if #(.EXP_W(8), .MANT_W(23)) bus ();

    fp_special_classify #(.EXP_W(8), .MANT_W(23), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .clr_flags    (clr_flags),
        .flag_invalid (flag_invalid),
        .bypass_cnt   (bypass_cnt)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    pair_t pend[$];
    exp_t  exp_q[$];
    logic  m_flag = 1'b0;
    int    m_cnt = 0;
    logic  held = 1'b0;
    logic [39:0] held_v;
    logic  acc;
    bit    rnd_valid = 0;
    bit    rnd_ready = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic fp_class_t cls_of(input logic [31:0] w);
        int e;
        int m;
        e = int'(w[30:23]);
        m = int'(w[22:0]);
        if (e == 255) begin
            if (m == 0) return FPC_INF;
            if (m >= (1 << 22)) return FPC_QNAN;
            return FPC_SNAN;
        end
        if (e == 0) return (m == 0) ? FPC_ZERO : FPC_SUBN;
        return FPC_NORM;
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        exp_t        r;
        logic [31:0] bb;
        bb = b;
        bb[31] = b[31] ^ sub;
        r.ca = cls_of(a);
        r.cb = cls_of(bb);
        r.byp = 1'b1;
        r.res = 32'h0;
        r.inv = 1'b0;
        if (r.ca inside {FPC_QNAN, FPC_SNAN} || r.cb inside {FPC_QNAN, FPC_SNAN}) begin
            r.res = 32'h7FC00000;
            r.inv = (r.ca == FPC_SNAN) || (r.cb == FPC_SNAN);
        end else if (r.ca == FPC_INF && r.cb == FPC_INF && a[31] != bb[31]) begin
            r.res = 32'h7FC00000;
            r.inv = 1'b1;
        end else if (r.ca == FPC_INF) r.res = a;
        else if (r.cb == FPC_INF) r.res = bb;
        else if (r.ca == FPC_ZERO && r.cb == FPC_ZERO) r.res = (a[31] && bb[31]) ? 32'h80000000 : 32'h0;
        else if (r.ca == FPC_ZERO) r.res = bb;
        else if (r.cb == FPC_ZERO) r.res = a;
        else r.byp = 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 5))
            0: w[30:23] = 8'hFF;
            1: begin w[30:23] = 8'hFF; w[22:0] = 23'h0; end
            2: w[30:0] = 31'h0;
            3: w[30:23] = 8'h00;
            default: ;
        endcase
        return w;
    endfunction

    function automatic logic [39:0] snap();
        return {bus.class_a, bus.class_b, bus.bypass, bus.result, bus.invalid};
    endfunction

    task automatic add_pair(input logic [31:0] a, input logic [31:0] b, input logic sub);
        pair_t p;
        p.a = a; p.b = b; p.sub = sub; p.fixed = 1'b0; p.byp = 1'b0; p.res = 32'h0; p.inv = 1'b0;
        pend.push_back(p);
    endtask

    task automatic add_fixed(input logic [31:0] a, input logic [31:0] b, input logic sub,
                             input logic byp, input logic [31:0] res, input logic inv);
        pair_t p;
        p.a = a; p.b = b; p.sub = sub; p.fixed = 1'b1; p.byp = byp; p.res = res; p.inv = inv;
        pend.push_back(p);
    endtask

    task automatic tick();
        exp_t e;
        logic ohs;
        logic got;
        @(negedge clk);
        if (held) chk("hold_stable", {bus.out_valid, snap()}, {1'b1, held_v});
        chk("flag_invalid", flag_invalid, m_flag);
        chk("bypass_cnt", bypass_cnt, m_cnt);
        ohs = bus.out_valid && bus.out_ready;
        acc = bus.in_valid && bus.in_ready;
        got = 1'b0;
        if (ohs) begin
            if (exp_q.size() == 0) begin
                chk("spurious_output", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                got = 1'b1;
                chk("class_a", bus.class_a, e.ca);
                chk("class_b", bus.class_b, e.cb);
                chk("bypass", bus.bypass, e.byp);
                chk("result", bus.result, e.res);
                chk("invalid", bus.invalid, e.inv);
            end
        end
        if (clr_flags) begin m_flag = 1'b0; m_cnt = 0; end
        if (got) begin
            if (e.inv) m_flag = 1'b1;
            if (e.byp && m_cnt != 15) m_cnt++;
        end
        held = bus.out_valid && !bus.out_ready;
        held_v = snap();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        exp_t e;
        if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
        if (pend.size() > 0) begin
            bus.in_valid = rnd_valid ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.op_a = pend[0].a;
            bus.op_b = pend[0].b;
            bus.op_sub = pend[0].sub;
        end else begin
            bus.in_valid = 1'b0;
        end
        tick();
        if (acc) begin
            e = model(pend[0].a, pend[0].b, pend[0].sub);
            if (pend[0].fixed) begin
                e.byp = pend[0].byp;
                e.res = pend[0].res;
                e.inv = pend[0].inv;
            end
            exp_q.push_back(e);
            void'(pend.pop_front());
        end
    endtask

    task automatic run(input int budget);
        int n;
        n = 0;
        while ((pend.size() > 0 || exp_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        bus.in_valid = 1'b0;
        chk("drain_left", pend.size() + exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc;
        rst = 1'b1;
        clr_flags = 1'b0;
        bus.in_valid = 1'b0;
        bus.op_a = 32'h0;
        bus.op_b = 32'h0;
        bus.op_sub = 1'b0;
        bus.out_ready = 1'b1;
        #3;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_bypass", bus.bypass, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_invalid", bus.invalid, 0);
        chk("rst_class_a", bus.class_a, FPC_NORM);
        chk("rst_flag", flag_invalid, 0);
        chk("rst_cnt", bypass_cnt, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", bus.in_ready, 1);

        // inf - inf, two-cycle latency
        add_fixed(32'h7F800000, 32'h7F800000, 1'b1, 1'b1, 32'h7FC00000, 1'b1);
        step();
        chk("lat_cycle1_valid", bus.out_valid, 0);
        step();
        chk("lat_cycle2_valid", bus.out_valid, 1);
        chk("lat_result", bus.result, 32'h7FC00000);
        chk("lat_invalid", bus.invalid, 1);
        step();
        chk("lat_flag", flag_invalid, 1);
        chk("lat_cnt", bypass_cnt, 1);

        add_fixed(32'h80000000, 32'h80000000, 1'b0, 1'b1, 32'h80000000, 1'b0);
        add_fixed(32'h80000000, 32'h80000000, 1'b1, 1'b1, 32'h00000000, 1'b0);
        add_fixed(32'h3F800000, 32'h00000000, 1'b1, 1'b1, 32'h3F800000, 1'b0);
        add_fixed(32'h00000000, 32'h40000000, 1'b1, 1'b1, 32'hC0000000, 1'b0);
        add_fixed(32'h3F800000, 32'h40000000, 1'b0, 1'b0, 32'h00000000, 1'b0);
        add_fixed(32'h7F800001, 32'h3F800000, 1'b0, 1'b1, 32'h7FC00000, 1'b1);
        add_fixed(32'h7FC00001, 32'h3F800000, 1'b0, 1'b1, 32'h7FC00000, 1'b0);
        add_fixed(32'h00000001, 32'h00000000, 1'b0, 1'b1, 32'h00000001, 1'b0);
        add_fixed(32'hFF800000, 32'h7F800000, 1'b1, 1'b1, 32'hFF800000, 1'b0);
        add_fixed(32'h3F800000, 32'hFF800000, 1'b0, 1'b1, 32'hFF800000, 1'b0);
        run(100);

        // stall: 5 cycles of back-pressure with 6 pairs queued
        for (int i = 0; i < 6; i++) add_pair(rand_op(), rand_op(), 1'($urandom_range(0, 1)));
        bus.out_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (acc) n_acc++;
        end
        chk("stall_accepted", n_acc, 2);
        chk("stall_in_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        run(100);

        // saturation of the bypass counter
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        for (int i = 0; i < 20; i++)
            add_pair(32'h0, {1'($urandom_range(0, 1)), 8'h80, 23'($urandom)}, 1'($urandom_range(0, 1)));
        run(200);
        chk("sat_cnt", bypass_cnt, 15);

        // clear coinciding with a bypass handshake
        add_fixed(32'h7F800000, 32'h7F800000, 1'b1, 1'b1, 32'h7FC00000, 1'b1);
        step();
        step();
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        chk("clr_upd_flag", flag_invalid, 1);
        chk("clr_upd_cnt", bypass_cnt, 1);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        chk("clr_flag", flag_invalid, 0);
        chk("clr_cnt", bypass_cnt, 0);

        // randomized traffic with random stalls
        rnd_valid = 1;
        rnd_ready = 1;
        for (int i = 0; i < 300; i++) add_pair(rand_op(), rand_op(), 1'($urandom_range(0, 1)));
        run(3000);
        rnd_valid = 0;
        rnd_ready = 0;
        bus.out_ready = 1'b1;

        // reset with both stages occupied
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) add_fixed(32'h7F800000, 32'h7F800000, 1'b1, 1'b1, 32'h7FC00000, 1'b1);
        step();
        step();
        step();
        chk("pre_rst_valid", bus.out_valid, 1);
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_flag", flag_invalid, 0);
        chk("mid_rst_cnt", bypass_cnt, 0);
        pend.delete();
        exp_q.delete();
        m_flag = 1'b0;
        m_cnt = 0;
        held = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        for (int i = 0; i < 20; i++) add_pair(rand_op(), rand_op(), 1'($urandom_range(0, 1)));
        run(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
